cp0: RTL and testbench



---
 rtl/cp0_pkg.sv | 26 ++
 rtl/cp0_sync.sv | 23 ++
 rtl/cp0.sv | 88 ++++++++
 tb/tb_cp0.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register indices, SR/Cause bit positions and the
// interrupt handler vector also used by the next-PC unit.
package cp0_pkg;
  localparam logic [4:0]  CP0_SR    = 5'd12;
  localparam logic [4:0]  CP0_CAUSE = 5'd13;
  localparam logic [4:0]  CP0_EPC   = 5'd14;
  localparam logic [4:0]  CP0_PRID  = 5'd15;

  localparam int SR_IE  = 0;
  localparam int SR_EXL = 1;
  localparam int IM_LSB = 10;
  localparam int IM_MSB = 15;

  localparam logic [31:0] HANDLER_VEC = 32'h0000_4180;

  // SR image as seen by mfc0; unlisted bits are hardwired zero.
  function automatic logic [31:0] sr_pack(input logic [5:0] im, input logic exl,
                                          input logic ie);
    logic [31:0] r;
    r = '0;
    r[IM_MSB:IM_LSB] = im;
    r[SR_EXL]        = exl;
    r[SR_IE]         = ie;
    return r;
  endfunction
endpackage

// File: rtl/cp0_sync.sv
// Two-flop synchronizer for the hardware interrupt lines; flops clear on reset.
module cp0_sync #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] meta_q, sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/cp0.sv
// MIPS CP0: SR/Cause/EPC/PrID, interrupt request and ERET handling.
// Optional CP0_SYNC_HWINT_EN puts a 2-flop synchronizer in front of Cause.IP.
module cp0
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID      = 32'h0000_2295,
  parameter int          NUM_HWINT = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_HWINT-1:0] hwint,
  input  logic [31:0]          pc_ret,
  input  logic [4:0]           sel,
  input  logic [31:0]          din,
  input  logic                 we,
  input  logic                 eret,
  output logic                 intreq,
  output logic [31:0]          epc,
  output logic [31:0]          dout
);
  logic [NUM_HWINT-1:0] hwint_s;
  logic [NUM_HWINT-1:0] im_q, im_d, ip_q;
  logic                 exl_q, exl_d, ie_q, ie_d;
  logic [31:0]          epc_q, epc_d;

`ifdef CP0_SYNC_HWINT_EN
  cp0_sync #(.W(NUM_HWINT)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (hwint),
    .q_o (hwint_s)
  );
`else
  assign hwint_s = hwint;
`endif

  // eret masks the request so the next-PC unit never sees both in one cycle
  assign intreq = (|(ip_q & im_q)) & ie_q & ~exl_q & ~eret;

  always_comb begin
    im_d  = im_q;
    exl_d = exl_q;
    ie_d  = ie_q;
    epc_d = epc_q;
    if (intreq) begin
      // preempted instruction: any mtc0 this cycle is dropped
      epc_d = pc_ret;
      exl_d = 1'b1;
    end else begin
      if (we && sel == CP0_SR) begin
        im_d  = din[IM_MSB:IM_LSB];
        exl_d = din[SR_EXL];
        ie_d  = din[SR_IE];
      end
      if (we && sel == CP0_EPC) epc_d = din;
      if (eret) exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      im_q  <= '0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      ip_q  <= '0;
      epc_q <= '0;
    end else begin
      im_q  <= im_d;
      exl_q <= exl_d;
      ie_q  <= ie_d;
      ip_q  <= hwint_s;
      epc_q <= epc_d;
    end
  end

  assign epc = epc_q;

  always_comb begin
    dout = '0;
    case (sel)
      CP0_SR:    dout = sr_pack(im_q, exl_q, ie_q);
      CP0_CAUSE: dout[IM_MSB:IM_LSB] = ip_q;
      CP0_EPC:   dout = epc_q;
      CP0_PRID:  dout = PRID;
      default:   dout = '0;
    endcase
  end
endmodule

// File: tb/tb_cp0.sv
// Scoreboard bench for cp0: expectations queued at drive time, popped at check.
module tb_cp0;
`ifdef CP0_SYNC_HWINT_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst, we, eret;
  logic [5:0]  hwint;
  logic [31:0] pc_ret, din, epc, dout;
  logic [4:0]  sel;
  logic        intreq;

  logic [31:0] exp_q[$];
  logic [31:0] exp_v;
  int          n_checks = 0;
  int          n_fail   = 0;

  cp0 dut (
    .clk(clk), .rst(rst), .hwint(hwint), .pc_ret(pc_ret), .sel(sel),
    .din(din), .we(we), .eret(eret), .intreq(intreq), .epc(epc), .dout(dout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; hwint = 6'h3F; we = 1; sel = 5'd12; din = 32'hFFFF_FFFF;
    eret = 0; pc_ret = 32'h1111_1111;
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    exp_q.push_back(32'h0000_2295);
    tick();
    rst = 0; we = 0; din = 0;
    #1;
    exp_v = exp_q.pop_front(); n_checks++;
    if ({31'd0, intreq} !== exp_v) begin n_fail++; $display("FAIL reset_intreq got %h exp %h", intreq, exp_v); end
    exp_v = exp_q.pop_front(); n_checks++;
    if (epc !== exp_v) begin n_fail++; $display("FAIL reset_epc got %h exp %h", epc, exp_v); end
    sel = 5'd12; #1;
    exp_v = exp_q.pop_front(); n_checks++;
    if (dout !== exp_v) begin n_fail++; $display("FAIL reset_sr got %h exp %h", dout, exp_v); end
    sel = 5'd13; #1;
    exp_v = exp_q.pop_front(); n_checks++;
    if (dout !== exp_v) begin n_fail++; $display("FAIL reset_cause got %h exp %h", dout, exp_v); end
    sel = 5'd15; #1;
    exp_v = exp_q.pop_front(); n_checks++;
    if (dout !== exp_v) begin n_fail++; $display("FAIL reset_prid got %h exp %h", dout, exp_v); end
    hwint = 6'h00;
    for (int i = 0; i <= LAT; i++) tick();
  endtask

  task automatic test_take();
    we = 1; sel = 5'd12; din = 32'h0000_0401;
    tick();
    we = 0; hwint = 6'h01; pc_ret = 32'h0000_3010;
    exp_q.push_back(32'h0000_0401); exp_q.push_back(32'd0);
    #1;
    exp_v = exp_q.pop_front(); n_checks++;
    if (dout !== exp_v) begin n_fail++; $display("FAIL take_sr_write got %h exp %h", dout, exp_v); end
    exp_v = exp_q.pop_front(); n_checks++;
    if ({31'd0, intreq} !== exp_v) begin n_fail++; $display("FAIL take_pre_intreq got %h exp %h", intreq, exp_v); end
    for (int i = 0; i < LAT; i++) tick();
    exp_q.push_back(32'd1);
    exp_v = exp_q.pop_front(); n_checks++;
    if ({31'd0, intreq} !== exp_v) begin n_fail++; $display("FAIL take_intreq got %h exp %h", intreq, exp_v); end
    exp_q.push_back(32'h0000_3010); exp_q.push_back(32'h0000_0403); exp_q.push_back(32'd0);
    tick();
    exp_v = exp_q.pop_front(); n_checks++;
    if (epc !== exp_v) begin n_fail++; $display("FAIL take_epc got %h exp %h", epc, exp_v); end
    exp_v = exp_q.pop_front(); n_checks++;
    if (dout !== exp_v) begin n_fail++; $display("FAIL take_exl got %h exp %h", dout, exp_v); end
    exp_v = exp_q.pop_front(); n_checks++;
    if ({31'd0, intreq} !== exp_v) begin n_fail++; $display("FAIL take_post_intreq got %h exp %h", intreq, exp_v); end
  endtask

  task automatic test_eret();
    eret = 1;
    exp_q.push_back(32'd0); exp_q.push_back(32'h0000_0401); exp_q.push_back(32'd1);
    #1;
    exp_v = exp_q.pop_front(); n_checks++;
    if ({31'd0, intreq} !== exp_v) begin n_fail++; $display("FAIL eret_cycle_intreq got %h exp %h", intreq, exp_v); end
    tick();
    eret = 0; #1;
    exp_v = exp_q.pop_front(); n_checks++;
    if (dout !== exp_v) begin n_fail++; $display("FAIL eret_exl got %h exp %h", dout, exp_v); end
    exp_v = exp_q.pop_front(); n_checks++;
    if ({31'd0, intreq} !== exp_v) begin n_fail++; $display("FAIL eret_reraise got %h exp %h", intreq, exp_v); end
  endtask

  task automatic test_take_mtc0();
    we = 1; sel = 5'd14; din = 32'hDEAD_BEEF; pc_ret = 32'h0000_3020;
    exp_q.push_back(32'h0000_3020); exp_q.push_back(32'h0000_3020);
    tick();
    we = 0; #1;
    exp_v = exp_q.pop_front(); n_checks++;
    if (epc !== exp_v) begin n_fail++; $display("FAIL take_mtc0_epc got %h exp %h", epc, exp_v); end
    exp_v = exp_q.pop_front(); n_checks++;
    if (dout !== exp_v) begin n_fail++; $display("FAIL take_mtc0_dout got %h exp %h", dout, exp_v); end
  endtask

  task automatic test_mask();
    // SR write together with eret: EXL clear beats din[1]
    we = 1; sel = 5'd12; din = 32'h0000_0803; eret = 1;
    exp_q.push_back(32'h0000_0801); exp_q.push_back(32'd0); exp_q.push_back(32'h0000_0400);
    tick();
    we = 0; eret = 0; #1;
    exp_v = exp_q.pop_front(); n_checks++;
    if (dout !== exp_v) begin n_fail++; $display("FAIL mask_sr_eret got %h exp %h", dout, exp_v); end
    tick();
    exp_v = exp_q.pop_front(); n_checks++;
    if ({31'd0, intreq} !== exp_v) begin n_fail++; $display("FAIL mask_intreq got %h exp %h", intreq, exp_v); end
    sel = 5'd13; #1;
    exp_v = exp_q.pop_front(); n_checks++;
    if (dout !== exp_v) begin n_fail++; $display("FAIL mask_cause got %h exp %h", dout, exp_v); end
    eret = 1; sel = 5'd12;
    exp_q.push_back(32'h0000_0801);
    tick();
    eret = 0; #1;
    exp_v = exp_q.pop_front(); n_checks++;
    if (dout !== exp_v) begin n_fail++; $display("FAIL eret_exl0 got %h exp %h", dout, exp_v); end
  endtask

  task automatic test_readonly();
    we = 1; sel = 5'd14; din = 32'h1234_5678;
    exp_q.push_back(32'h1234_5678);
    tick();
    exp_v = exp_q.pop_front(); n_checks++;
    if (epc !== exp_v) begin n_fail++; $display("FAIL mtc0_epc got %h exp %h", epc, exp_v); end
    sel = 5'd13; din = 32'hFFFF_FFFF;
    exp_q.push_back(32'h0000_0400);
    tick();
    exp_v = exp_q.pop_front(); n_checks++;
    if (dout !== exp_v) begin n_fail++; $display("FAIL cause_ro got %h exp %h", dout, exp_v); end
    sel = 5'd15; din = 32'd0;
    exp_q.push_back(32'h0000_2295);
    tick();
    exp_v = exp_q.pop_front(); n_checks++;
    if (dout !== exp_v) begin n_fail++; $display("FAIL prid_ro got %h exp %h", dout, exp_v); end
    sel = 5'd3; din = 32'hFFFF_FFFF;
    exp_q.push_back(32'd0);
    #1;
    exp_v = exp_q.pop_front(); n_checks++;
    if (dout !== exp_v) begin n_fail++; $display("FAIL other_idx got %h exp %h", dout, exp_v); end
    tick();
    sel = 5'd12; din = 32'h0000_FC01;
    exp_q.push_back(32'h0000_0801); exp_q.push_back(32'h0000_FC01); exp_q.push_back(32'd1);
    #1;
    exp_v = exp_q.pop_front(); n_checks++;
    if (dout !== exp_v) begin n_fail++; $display("FAIL read_old got %h exp %h", dout, exp_v); end
    tick();
    we = 0; #1;
    exp_v = exp_q.pop_front(); n_checks++;
    if (dout !== exp_v) begin n_fail++; $display("FAIL sr_new got %h exp %h", dout, exp_v); end
    exp_v = exp_q.pop_front(); n_checks++;
    if ({31'd0, intreq} !== exp_v) begin n_fail++; $display("FAIL unmask_intreq got %h exp %h", intreq, exp_v); end
  endtask

  task automatic test_reset_drop();
    rst = 1;
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    tick();
    rst = 0; #1;
    exp_v = exp_q.pop_front(); n_checks++;
    if ({31'd0, intreq} !== exp_v) begin n_fail++; $display("FAIL reset_drop_intreq got %h exp %h", intreq, exp_v); end
    exp_v = exp_q.pop_front(); n_checks++;
    if (epc !== exp_v) begin n_fail++; $display("FAIL reset_drop_epc got %h exp %h", epc, exp_v); end
  endtask

  initial begin
    test_reset();
    test_take();
    test_eret();
    test_take_mtc0();
    test_mask();
    test_readonly();
    test_reset_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
